// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences the shared-memory datapath,
// stalls on mem_ready, halts on illegal opcodes, counts retirements.
module mips_multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic [3:0]         state,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12,
    HALT     = 4'd13
  } state_t;

  state_t cur, nxt;
  logic   retire;

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    unique case (cur)
      IDLE:     nxt = FETCH;
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (Op)
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDI_EX;
          default:      nxt = HALT;
        endcase
      end
      MEM_ADDR: nxt = (Op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR: begin
        nxt    = mem_ready ? FETCH : MEM_WR;
        retire = mem_ready;
      end
      EXEC:     nxt = R_WB;
      ADDI_EX:  nxt = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      default:  nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (retire)
        instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state = cur;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    unique case (cur)
      IDLE: ;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEM_ADDR, ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDI_WB:  RegWrite = 1'b1;
      default:  halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: driver queues hand-written per-cycle expectations,
// monitor pops and compares them on the falling edge.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, halted;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [3:0] instr_count;

  mips_multicycle_control #(.COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010, AI = 6'b001000;
  localparam logic [5:0] XX = 6'b111111;

  // {PCWr,PCWrC,IorD,MemRd,MemWr,IRWr,M2R,RegDst,RegWr,SrcA,SrcB,ALUOp,PCSrc,halted}
  localparam logic [16:0] C_IDLE = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FSTL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FRDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_ADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_HALT = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       q[$];
  int         vecs = 0;
  int         errs = 0;
  logic [3:0] ec;

  task automatic step(input logic r, input logic [5:0] op,
                      input logic mr, input logic [3:0] st,
                      input logic [16:0] ctrl, input logic [3:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    Op        = op;
    mem_ready = mr;
    e.st   = st;
    e.ctrl = ctrl;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic fetch_rdy();
    step(0, XX, 1, 4'd1, C_FRDY, ec);
  endtask

  task automatic do_lw();
    fetch_rdy();
    step(0, LW, 1, 4'd2, C_DEC, ec);
    step(0, LW, 1, 4'd3, C_ADDR, ec);
    step(0, XX, 1, 4'd4, C_MRD, ec);
    step(0, XX, 1, 4'd5, C_MWB, ec);
    ec = ec + 4'd1;
  endtask

  task automatic do_r(input int stall);
    for (int i = 0; i < stall; i++)
      step(0, XX, 0, 4'd1, C_FSTL, ec);
    fetch_rdy();
    step(0, RT, 1, 4'd2, C_DEC, ec);
    step(0, XX, 1, 4'd7, C_EXEC, ec);
    step(0, XX, 1, 4'd8, C_RWB, ec);
    ec = ec + 4'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [16:0] act;
    if (q.size() != 0) begin
      e   = q.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, halted};
      vecs++;
      if (state !== e.st) begin
        errs++;
        $display("FAIL state vec %0d: got %0d want %0d", vecs, state, e.st);
      end
      if (act !== e.ctrl) begin
        errs++;
        $display("FAIL ctrl vec %0d st %0d: got %b want %b",
                 vecs, e.st, act, e.ctrl);
      end
      if (instr_count !== e.cnt) begin
        errs++;
        $display("FAIL count vec %0d: got %0d want %0d",
                 vecs, instr_count, e.cnt);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    Op        = RT;
    mem_ready = 1'b0;
    ec        = 4'd0;

    step(1, RT, 0, 4'd0, C_IDLE, 4'd0);
    step(1, RT, 1, 4'd0, C_IDLE, 4'd0);
    step(0, XX, 1, 4'd0, C_IDLE, 4'd0);

    do_lw();

    fetch_rdy();
    step(0, SW, 1, 4'd2, C_DEC, ec);
    step(0, SW, 1, 4'd3, C_ADDR, ec);
    step(0, XX, 0, 4'd6, C_MWR, ec);
    step(0, LW, 0, 4'd6, C_MWR, ec);
    step(0, XX, 0, 4'd6, C_MWR, ec);
    step(0, XX, 1, 4'd6, C_MWR, ec);
    ec = ec + 4'd1;

    do_r(2);

    fetch_rdy();
    step(0, BQ, 1, 4'd2, C_DEC, ec);
    step(0, XX, 1, 4'd9, C_BR, ec);
    ec = ec + 4'd1;

    fetch_rdy();
    step(0, JP, 1, 4'd2, C_DEC, ec);
    step(0, XX, 1, 4'd10, C_JMP, ec);
    ec = ec + 4'd1;

    fetch_rdy();
    step(0, AI, 1, 4'd2, C_DEC, ec);
    step(0, XX, 1, 4'd11, C_ADDR, ec);
    step(0, XX, 1, 4'd12, C_AWB, ec);
    ec = ec + 4'd1;

    for (int i = 0; i < 16; i++)
      do_r(0);

    // reset lands mid-cycle while sitting in MEM_RD
    fetch_rdy();
    step(0, LW, 1, 4'd2, C_DEC, ec);
    step(0, LW, 1, 4'd3, C_ADDR, ec);
    step(0, XX, 0, 4'd4, C_MRD, ec);
    step(1, LW, 0, 4'd0, C_IDLE, 4'd0);
    ec = 4'd0;
    step(0, XX, 1, 4'd0, C_IDLE, ec);
    do_lw();

    fetch_rdy();
    step(0, XX, 1, 4'd2, C_DEC, ec);
    for (int i = 0; i < 10; i++)
      step(0, (i % 2 == 0) ? LW : RT, i[0], 4'd13, C_HALT, ec);
    step(1, XX, 1, 4'd0, C_IDLE, 4'd0);
    ec = 4'd0;
    step(0, XX, 1, 4'd0, C_IDLE, ec);
    step(0, XX, 0, 4'd1, C_FSTL, ec);
    fetch_rdy();

    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle variant of the MIPS datapath: one shared memory, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Decodes the instruction opcode and issues per-cycle datapath enables and mux selects.
- Stalls on a memory-ready handshake, halts on an illegal opcode, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Op  input  6  opcode, taken from IR[31:26].
- mem_ready  input  1  memory completes the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemToReg  output  1  write-back select: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU operand B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  output  2  to ALU control: 00 = add, 01 = sub, 10 = use funct.
- PCSource  output  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state, for debug.
- halted  output  1  high while in HALT.
- instr_count  output  COUNT_W  retired-instruction counter.

Behaviour:
- Reset (asynchronous): state = IDLE(0), instr_count = 0, and every control output = 0. Reset asserted mid-instruction aborts the instruction immediately; there is no partial retirement.
- All outputs decode combinationally from state. The only exception is the mem_ready gating listed under FETCH. Any output not listed for a state is 0.
- Opcodes decoded:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- State encodings, outputs and transitions:
  - IDLE(0): outputs all 0 -> FETCH.
  - FETCH(1):
    - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
    - IRWrite and PCWrite = mem_ready.
    - Stays in FETCH while mem_ready=0, holding MemRead; -> DECODE when mem_ready=1.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
    - lw or sw -> MEM_ADDR
    - R-type -> EXEC
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EX
    - any other opcode -> HALT
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD(4): MemRead=1, IorD=1. Waits on mem_ready; -> MEM_WB when mem_ready=1.
  - MEM_WB(5): RegWrite=1, MemToReg=1, RegDst=0 -> FETCH. Retires.
  - MEM_WR(6): MemWrite=1, IorD=1. Waits on mem_ready; -> FETCH when mem_ready=1. Retires on that exit.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
  - R_WB(8): RegWrite=1, RegDst=1, MemToReg=0 -> FETCH. Retires.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH. Retires whether or not the branch is taken.
  - JUMP(10): PCWrite=1, PCSource=10 -> FETCH. Retires.
  - ADDI_EX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  - ADDI_WB(12): RegWrite=1, RegDst=0, MemToReg=0 -> FETCH. Retires.
  - HALT(13): halted=1, all other outputs 0. Remains in HALT until reset.
  - Encodings 14–15: treated as HALT (next state HALT, halted=1).
- Cycles per instruction (with mem_ready tied high): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- instr_count:
  - Increments by 1 on the clock edge that leaves a retiring state for FETCH.
  - Wraps modulo 2^COUNT_W with no saturation.
  - Frozen while in HALT.
- Op is sampled only in DECODE and MEM_ADDR. Op changing in any other state has no effect.

Test Plan:
- Assert reset mid-MEM_RD -> state=0 and all outputs 0 immediately, without waiting for a clock edge. After release: 1 cycle in IDLE, then FETCH with MemRead=1.
- mem_ready=1, Op=100011 (lw) -> state sequence 1,2,3,4,5,1; RegWrite=1 and MemToReg=1 only in state 5; instr_count 0->1.
- Op=101011 (sw) with mem_ready held 0 for 3 cycles in MEM_WR -> MemWrite=1 and IorD=1 for 4 cycles, then FETCH. Total 7 cycles; RegWrite never asserted.
- In FETCH, mem_ready=0 for 2 cycles -> IRWrite=0 and PCWrite=0 during the stall; both pulse for exactly 1 cycle when mem_ready=1.
- Op=000100 (beq) -> BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01, then FETCH. Op=000010 (j) -> JUMP shows PCWrite=1, PCSource=10. CPI = 3 for each.
- Op=111111 in DECODE -> HALT with halted=1. instr_count unchanged over 10 further cycles; reset recovers to IDLE.
- With COUNT_W=4, run 16 R-type instructions -> instr_count wraps from 15 to 0.
